// File: rtl/rot_led_cmd_ctrl.sv
// Rotating-LED command sequencer: UART/button arbitration, run/dir state, position stepping, digit codes, UART ack.
// Latency: a UART byte acts 2 cycles after rx_done_tick, display 1 cycle after pos. Backpressure: 1 ack in flight + 1 held; further acks drop and set ack_ovf.
module rot_led_cmd_ctrl #(
  parameter int unsigned N          = 25_000_000,
  parameter logic [4:0]  CODE_UP    = 5'h10,
  parameter logic [4:0]  CODE_DN    = 5'h11,
  parameter logic [4:0]  CODE_BLANK = 5'h12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       send_go,
  input  logic       send_pause,
  input  logic       send_reverse,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [4:0] in_0,
  output logic [4:0] in_1,
  output logic [4:0] in_2,
  output logic [4:0] in_3,
  output logic       running,
  output logic       reverse,
  output logic       ack_ovf
);

  localparam int unsigned   CW      = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
  localparam logic [7:0] CMD_GO = 8'h47, CMD_PAUSE = 8'h50, CMD_REV = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53, ACK_UNK = 8'h3F;

  typedef enum logic { PAUSED, RUN } run_t;
  typedef enum logic [1:0] { TX_IDLE, TX_SEND, TX_WAIT } tx_t;

  run_t run_q, run_nxt;
  tx_t  tx_state, tx_nxt;

  logic          uart_vld;
  logic [7:0]    uart_byte;
  logic          pend_go, pend_pause, pend_rev;
  logic          cmd_go, cmd_pause, cmd_rev, cmd_step, cmd_known;
  logic          svc_go, svc_pause, svc_rev;
  logic [CW-1:0] cnt;
  logic          presc_tick, step;
  logic [2:0]    pos;
  logic          reverse_q;
  logic [3:0][4:0] disp, disp_q;
  logic          hold_vld;
  logic [7:0]    hold_dat;
  logic [7:0]    ack_byte;
  logic          ack_take, ack_drop, tx_load;

  // UART byte always wins; buttons wait in sticky pending flags.
  always_comb begin
    cmd_go    = 1'b0;
    cmd_pause = 1'b0;
    cmd_rev   = 1'b0;
    cmd_step  = 1'b0;
    cmd_known = 1'b0;
    svc_go    = 1'b0;
    svc_pause = 1'b0;
    svc_rev   = 1'b0;
    if (uart_vld) begin
      cmd_known = 1'b1;
      case (uart_byte)
        CMD_GO:    cmd_go    = 1'b1;
        CMD_PAUSE: cmd_pause = 1'b1;
        CMD_REV:   cmd_rev   = 1'b1;
        CMD_STEP:  cmd_step  = 1'b1;
        default:   cmd_known = 1'b0;
      endcase
    end else if (pend_rev) begin
      cmd_rev = 1'b1;
      svc_rev = 1'b1;
    end else if (pend_pause) begin
      cmd_pause = 1'b1;
      svc_pause = 1'b1;
    end else if (pend_go) begin
      cmd_go = 1'b1;
      svc_go = 1'b1;
    end
  end

  always_comb begin
    run_nxt = run_q;
    case (run_q)
      PAUSED: if (cmd_go)    run_nxt = RUN;
      RUN:    if (cmd_pause) run_nxt = PAUSED;
    endcase
  end

  assign presc_tick = (run_q == RUN) && (cnt == CNT_MAX);
  // Steps use the pre-toggle direction when a reverse lands in the same cycle.
  assign step       = presc_tick || (cmd_step && (run_q == PAUSED));

  always_comb begin
    disp = {4{CODE_BLANK}};
    if (!pos[2]) disp[pos[1:0]]  = CODE_UP;
    else         disp[~pos[1:0]] = CODE_DN;
  end

  always_comb begin
    tx_nxt   = tx_state;
    tx_load  = 1'b0;
    tx_start = 1'b0;
    case (tx_state)
      TX_IDLE: if (hold_vld) begin
        tx_load = 1'b1;
        tx_nxt  = TX_SEND;
      end
      TX_SEND: begin
        tx_start = 1'b1;
        tx_nxt   = TX_WAIT;
      end
      TX_WAIT: if (tx_done_tick) tx_nxt = TX_IDLE;
      default: tx_nxt = TX_IDLE;
    endcase
  end

  assign ack_byte = cmd_known ? uart_byte : ACK_UNK;
  // The holding slot frees up in the same cycle the FSM loads it.
  assign ack_take = uart_vld && (!hold_vld || tx_load);
  assign ack_drop = uart_vld && hold_vld && !tx_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uart_vld   <= 1'b0;
      uart_byte  <= '0;
      pend_go    <= 1'b0;
      pend_pause <= 1'b0;
      pend_rev   <= 1'b0;
      run_q      <= PAUSED;
      reverse_q  <= 1'b0;
      cnt        <= '0;
      pos        <= '0;
      disp_q     <= {CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_UP};
      hold_vld   <= 1'b0;
      hold_dat   <= '0;
      tx_state   <= TX_IDLE;
      tx_data    <= '0;
      ack_ovf    <= 1'b0;
    end else begin
      uart_vld   <= rx_done_tick;
      if (rx_done_tick) uart_byte <= rx_data;
      pend_go    <= send_go      | (pend_go    & ~svc_go);
      pend_pause <= send_pause   | (pend_pause & ~svc_pause);
      pend_rev   <= send_reverse | (pend_rev   & ~svc_rev);
      run_q      <= run_nxt;
      reverse_q  <= reverse_q ^ cmd_rev;
      if (run_q == RUN) cnt <= presc_tick ? '0 : cnt + 1'b1;
      if (step) pos <= reverse_q ? pos - 3'd1 : pos + 3'd1;
      disp_q     <= disp;
      if (ack_take) begin
        hold_vld <= 1'b1;
        hold_dat <= ack_byte;
      end else if (tx_load) begin
        hold_vld <= 1'b0;
      end
      tx_state   <= tx_nxt;
      if (tx_load) tx_data <= hold_dat;
      ack_ovf    <= ack_ovf | ack_drop;
    end
  end

  assign running = (run_q == RUN);
  assign reverse = reverse_q;
  assign in_0    = disp_q[0];
  assign in_1    = disp_q[1];
  assign in_2    = disp_q[2];
  assign in_3    = disp_q[3];

endmodule
